// File: rtl/crc8_frame_checker_if.sv
// Byte-stream, payload-stream and result handshakes of the CRC8 frame checker.
// The master side feeds frames in and consumes payload/results; the checker is the slave.
interface crc8_frame_checker_if #(
    parameter int LEN_W = 8
) ();
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_last;

    logic             m_valid;
    logic             m_ready;
    logic [7:0]       m_data;
    logic             m_last;

    logic             res_valid;
    logic             res_ready;
    logic             res_ok;
    logic             res_err_short;
    logic             res_err_long;
    logic [LEN_W-1:0] res_len;
    logic [7:0]       res_crc_calc;
    logic [7:0]       res_crc_rx;

    modport master (
        output s_valid, s_data, s_last, m_ready, res_ready,
        input  s_ready, m_valid, m_data, m_last,
        input  res_valid, res_ok, res_err_short, res_err_long,
        input  res_len, res_crc_calc, res_crc_rx
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready, res_ready,
        output s_ready, m_valid, m_data, m_last,
        output res_valid, res_ok, res_err_short, res_err_long,
        output res_len, res_crc_calc, res_crc_rx
    );
endinterface

// File: rtl/crc8_frame_checker.sv
// CRC8 (poly 0x07, MSB-first) frame checker: strips the trailing CRC byte, forwards the
// payload one byte late, and reports one registered pass/fail result per frame.
module crc8_frame_checker #(
    parameter logic [7:0] CRC_INIT = 8'h00,
    parameter int          LEN_W    = 8,
    parameter int          MAX_LEN  = 255,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    crc8_frame_checker_if.slave  io,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_REPORT
    } state_e;

    localparam logic [LEN_W-1:0] LEN_SAT   = '1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    // Whole-byte update: eight serial shifts of the XORed value, unrolled by synthesis.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] x;
        x = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
        end
        return x;
    endfunction

    state_e           state_q,         state_d;
    logic [7:0]       crc_q,           crc_d;
    logic [7:0]       hold_data_q,     hold_data_d;
    logic             hold_full_q,     hold_full_d;
    logic             m_valid_q,       m_valid_d;
    logic [7:0]       m_data_q,        m_data_d;
    logic             m_last_q,        m_last_d;
    logic [LEN_W-1:0] len_q,           len_d;
    logic             err_long_q,      err_long_d;
    logic             res_valid_q,     res_valid_d;
    logic             res_ok_q,        res_ok_d;
    logic             res_err_short_q, res_err_short_d;
    logic             res_err_long_q,  res_err_long_d;
    logic [LEN_W-1:0] res_len_q,       res_len_d;
    logic [7:0]       res_crc_calc_q,  res_crc_calc_d;
    logic [7:0]       res_crc_rx_q,    res_crc_rx_d;
    logic [CNT_W-1:0] pass_cnt_q,      pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q,      fail_cnt_d;

    logic       s_ready;
    logic       accept;
    logic [7:0] crc_next;
    logic       frame_ok;

    assign s_ready  = (state_q != ST_REPORT) && (!m_valid_q || io.m_ready);
    assign accept   = io.s_valid && s_ready;
    assign crc_next = crc8_byte(crc_q, io.s_data);

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through the case can infer a latch.
        state_d         = state_q;
        crc_d           = crc_q;
        hold_data_d     = hold_data_q;
        hold_full_d     = hold_full_q;
        m_valid_d       = m_valid_q;
        m_data_d        = m_data_q;
        m_last_d        = m_last_q;
        len_d           = len_q;
        err_long_d      = err_long_q;
        res_valid_d     = res_valid_q;
        res_ok_d        = res_ok_q;
        res_err_short_d = res_err_short_q;
        res_err_long_d  = res_err_long_q;
        res_len_d       = res_len_q;
        res_crc_calc_d  = res_crc_calc_q;
        res_crc_rx_d    = res_crc_rx_q;
        pass_cnt_d      = pass_cnt_q;
        fail_cnt_d      = fail_cnt_q;
        frame_ok        = 1'b0;

        if (m_valid_q && io.m_ready) begin
            m_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE, ST_BODY: begin
                if (accept) begin
                    crc_d = crc_next;
                    if (!io.s_last) begin
                        hold_data_d = io.s_data;
                        hold_full_d = 1'b1;
                        if (hold_full_q) begin
                            m_valid_d = 1'b1;
                            m_data_d  = hold_data_q;
                            m_last_d  = 1'b0;
                        end
                        len_d = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
                        // Testing the old count keeps err_long correct even when it has saturated.
                        if (len_q >= MAX_LEN_L) begin
                            err_long_d = 1'b1;
                        end
                        state_d = ST_BODY;
                    end else begin
                        if (hold_full_q) begin
                            m_valid_d = 1'b1;
                            m_data_d  = hold_data_q;
                            m_last_d  = 1'b1;
                        end
                        hold_full_d     = 1'b0;
                        frame_ok        = (crc_next == 8'h00) && (state_q != ST_IDLE) && !err_long_q;
                        res_valid_d     = 1'b1;
                        res_ok_d        = frame_ok;
                        res_err_short_d = (state_q == ST_IDLE);
                        res_err_long_d  = err_long_q;
                        res_len_d       = len_q;
                        res_crc_calc_d  = crc_q;
                        res_crc_rx_d    = io.s_data;
                        if (frame_ok) begin
                            pass_cnt_d = (pass_cnt_q == CNT_SAT) ? pass_cnt_q : pass_cnt_q + 1'b1;
                        end else begin
                            fail_cnt_d = (fail_cnt_q == CNT_SAT) ? fail_cnt_q : fail_cnt_q + 1'b1;
                        end
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                // A stalled final payload byte may still drain here; the result does not wait for it.
                if (res_valid_q && io.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    crc_d       = CRC_INIT;
                    len_d       = '0;
                    err_long_d  = 1'b0;
                    hold_full_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            crc_q           <= CRC_INIT;
            hold_data_q     <= '0;
            hold_full_q     <= 1'b0;
            m_valid_q       <= 1'b0;
            m_data_q        <= '0;
            m_last_q        <= 1'b0;
            len_q           <= '0;
            err_long_q      <= 1'b0;
            res_valid_q     <= 1'b0;
            res_ok_q        <= 1'b0;
            res_err_short_q <= 1'b0;
            res_err_long_q  <= 1'b0;
            res_len_q       <= '0;
            res_crc_calc_q  <= '0;
            res_crc_rx_q    <= '0;
            pass_cnt_q      <= '0;
            fail_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            crc_q           <= crc_d;
            hold_data_q     <= hold_data_d;
            hold_full_q     <= hold_full_d;
            m_valid_q       <= m_valid_d;
            m_data_q        <= m_data_d;
            m_last_q        <= m_last_d;
            len_q           <= len_d;
            err_long_q      <= err_long_d;
            res_valid_q     <= res_valid_d;
            res_ok_q        <= res_ok_d;
            res_err_short_q <= res_err_short_d;
            res_err_long_q  <= res_err_long_d;
            res_len_q       <= res_len_d;
            res_crc_calc_q  <= res_crc_calc_d;
            res_crc_rx_q    <= res_crc_rx_d;
            pass_cnt_q      <= pass_cnt_d;
            fail_cnt_q      <= fail_cnt_d;
        end
    end

    assign io.s_ready       = s_ready;
    assign io.m_valid       = m_valid_q;
    assign io.m_data        = m_data_q;
    assign io.m_last        = m_last_q;
    assign io.res_valid     = res_valid_q;
    assign io.res_ok        = res_ok_q;
    assign io.res_err_short = res_err_short_q;
    assign io.res_err_long  = res_err_long_q;
    assign io.res_len       = res_len_q;
    assign io.res_crc_calc  = res_crc_calc_q;
    assign io.res_crc_rx    = res_crc_rx_q;
    assign pass_cnt         = pass_cnt_q;
    assign fail_cnt         = fail_cnt_q;

endmodule
